// File: rtl/calc_opcode_encoder.sv
// calc_opcode_encoder: pushbutton front-end for the 4-bit calculator.
// Debounces NEXT/COMMIT and steps through the five operations. On a COMMIT
// press it latches operands A/B from the switches and issues one {OP,A,B}
// beat over a valid/ready handshake.
// Optional feature macro: AUTO_REPEAT_EN (auto-repeat of NEXT while held).

// Per-button synchronizer + debouncer. The output level is active-high (1 = pressed).
module calc_debounce #(
    parameter int CYCLES = 500000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_n,
    output logic pressed
);
    localparam int CW = (CYCLES > 1) ? $clog2(CYCLES) : 1;

    logic [1:0]    sync_q;
    logic [CW-1:0] cnt;
    logic          lvl;

    assign lvl = ~sync_q[1];

    // Two-flop synchronizer. It resets to the released (high) level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync_q <= 2'b11;
        else        sync_q <= {sync_q[0], btn_n};
    end

    // Accept a new level only after it has stayed stable for CYCLES cycles.
    // Any return to the accepted level restarts the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            pressed <= 1'b0;
        end else if (lvl == pressed) begin
            cnt <= '0;
        end else if (cnt == CW'(CYCLES - 1)) begin
            pressed <= lvl;
            cnt     <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end
endmodule

module calc_opcode_encoder #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_CYCLES   = 25000000
) (
    input  logic       CLOCK_50,
    input  logic       RST_N,
    input  logic [1:0] BTN_N,
    input  logic [7:0] SW,
    output logic [2:0] OP,
    output logic [3:0] A,
    output logic [3:0] B,
    output logic       VALID,
    input  logic       READY,
    output logic [2:0] SEL
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_REL} state_t;

    state_t     state_q, state_d;
    logic [1:0] db, db_q, press;
    logic [2:0] sel_d;
    logic       latch;
    logic       rep_tick;

    // Map the operation index to the calculator's KEY-style opcode.
    function automatic logic [2:0] encode(input logic [2:0] s);
        case (s)
            3'd0:    encode = 3'b000;
            3'd1:    encode = 3'b001;
            3'd2:    encode = 3'b101;
            3'd3:    encode = 3'b110;
            3'd4:    encode = 3'b010;
            default: encode = 3'b000;
        endcase
    endfunction

    for (genvar i = 0; i < 2; i++) begin : g_btn
        calc_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db (
            .clk     (CLOCK_50),
            .rst_n   (RST_N),
            .btn_n   (BTN_N[i]),
            .pressed (db[i])
        );
    end

    // Previous debounced level. It is used to turn each press into a one-cycle event.
    always_ff @(posedge CLOCK_50 or negedge RST_N) begin
        if (!RST_N) db_q <= 2'b00;
        else        db_q <= db;
    end

    assign press = db & ~db_q;
    assign VALID = (state_q == ISSUE);

`ifdef AUTO_REPEAT_EN
    localparam int RW = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
    logic [RW-1:0] rep_cnt;

    // Hold timer for NEXT. It is cleared on release or whenever the FSM is outside IDLE.
    always_ff @(posedge CLOCK_50 or negedge RST_N) begin
        if (!RST_N)                          rep_cnt <= '0;
        else if (state_q != IDLE || !db[0])  rep_cnt <= '0;
        else if (rep_cnt == RW'(REPEAT_CYCLES - 1)) rep_cnt <= '0;
        else                                 rep_cnt <= rep_cnt + 1'b1;
    end

    assign rep_tick = (state_q == IDLE) && db[0] && (rep_cnt == RW'(REPEAT_CYCLES - 1));
`else
    assign rep_tick = 1'b0;
`endif

    // Next-state logic. COMMIT beats NEXT in IDLE, and NEXT is ignored in other states.
    always_comb begin
        state_d = state_q;
        sel_d   = SEL;
        latch   = 1'b0;
        case (state_q)
            IDLE: begin
                if (press[1]) begin
                    latch   = 1'b1;
                    state_d = ISSUE;
                end else if (press[0] || rep_tick) begin
                    sel_d = (SEL == 3'd4) ? 3'd0 : SEL + 3'd1;
                end
            end
            ISSUE:    if (READY) state_d = WAIT_REL;
            WAIT_REL: if (!db[1]) state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // State, selection/opcode and operand registers. OP always tracks SEL.
    always_ff @(posedge CLOCK_50 or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= IDLE;
            SEL     <= 3'd0;
            OP      <= 3'b000;
            A       <= 4'd0;
            B       <= 4'd0;
        end else begin
            state_q <= state_d;
            SEL     <= sel_d;
            OP      <= encode(sel_d);
            if (latch) begin
                A <= SW[7:4];
                B <= SW[3:0];
            end
        end
    end
endmodule

// File: tb/tb_calc_opcode_encoder.sv
// Scoreboard bench for calc_opcode_encoder (DEBOUNCE_CYCLES=4, REPEAT_CYCLES=20).
module tb_calc_opcode_encoder;
    localparam int DB = 4;
    localparam int RC = 20;

    logic       CLOCK_50 = 1'b0;
    logic       RST_N;
    logic [1:0] BTN_N;
    logic [7:0] SW;
    logic       READY;
    logic [2:0] OP;
    logic [3:0] A;
    logic [3:0] B;
    logic       VALID;
    logic [2:0] SEL;

    calc_opcode_encoder #(.DEBOUNCE_CYCLES(DB), .REPEAT_CYCLES(RC)) dut (
        .CLOCK_50 (CLOCK_50),
        .RST_N    (RST_N),
        .BTN_N    (BTN_N),
        .SW       (SW),
        .OP       (OP),
        .A        (A),
        .B        (B),
        .VALID    (VALID),
        .READY    (READY),
        .SEL      (SEL)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    typedef struct packed {
        logic [2:0] op;
        logic [3:0] a;
        logic [3:0] b;
    } txn_t;

    int   vectors = 0;
    int   miscompares = 0;
    int   beats = 0;
    int   msel = 0;
    txn_t sb[$];
    txn_t got, exp_t;
    logic [2:0] opc [5] = '{3'b000, 3'b001, 3'b101, 3'b110, 3'b010};

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge CLOCK_50);
        #1;
    endtask

    task automatic next_press();
        BTN_N[0] = 1'b0;
        step(10);
        BTN_N[0] = 1'b1;
        step(10);
        msel = (msel + 1) % 5;
    endtask

    task automatic expect_txn(input logic [7:0] sw);
        sb.push_back('{op: opc[msel], a: sw[7:4], b: sw[3:0]});
    endtask

    task automatic wait_valid();
        int n = 0;
        while (!VALID && n < 50) begin
            step(1);
            n++;
        end
        check("valid_timeout", int'(VALID), 1);
    endtask

    // Monitor: every accepted beat must match the oldest expected transaction.
    always @(negedge CLOCK_50) begin
        if (RST_N && VALID && READY) begin
            beats++;
            vectors++;
            got = {OP, A, B};
            if (sb.size() == 0) begin
                miscompares++;
                $display("FAIL beat_unexpected: got op=%b a=%0d b=%0d expected none", OP, A, B);
            end else begin
                exp_t = sb.pop_front();
                if (got !== exp_t) begin
                    miscompares++;
                    $display("FAIL beat: got op=%b a=%0d b=%0d expected op=%b a=%0d b=%0d",
                             OP, A, B, exp_t.op, exp_t.a, exp_t.b);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] sw;
        int b0, sel0;
        RST_N = 1'b0;
        BTN_N = 2'b11;
        SW    = 8'h00;
        READY = 1'b0;
        step(3);
        check("rst_op", OP, 0);
        check("rst_sel", SEL, 0);
        check("rst_valid", VALID, 0);
        check("rst_ab", {A, B}, 0);
        RST_N = 1'b1;
        step(3);
        check("post_rst_op", OP, 0);
        check("post_rst_valid", VALID, 0);

        // Walk through all five operations and wrap back to ADD.
        for (int i = 0; i < 5; i++) begin
            next_press();
            check("walk_sel", SEL, msel);
            check("walk_op", OP, opc[msel]);
        end
        check("walk_wrap", SEL, 0);

        // Directed commit with SEL=2 and READY held off for 5 cycles.
        next_press();
        next_press();
        SW = 8'h3A;
        expect_txn(SW);
        BTN_N[1] = 1'b0;
        // Expected latency: 2 sync cycles plus DB stable cycles give the debounced press, then 1 more cycle.
        step(2 + DB);
        check("valid_early", VALID, 0);
        step(1);
        check("valid_latency", VALID, 1);
        SW = 8'hFF;
        for (int i = 0; i < 5; i++) begin
            check("hold_valid", VALID, 1);
            check("hold_op", OP, 3'b101);
            check("hold_ab", {A, B}, 8'h3A);
            step(1);
        end
        READY = 1'b1;
        step(1);
        check("valid_fall", VALID, 0);
        READY = 1'b0;
        BTN_N[1] = 1'b1;
        step(15);
        check("ab_kept", {A, B}, 8'h3A);

        // A short glitch on NEXT must not advance the selection.
        BTN_N[0] = 1'b0;
        step(2);
        BTN_N[0] = 1'b1;
        step(15);
        check("glitch_sel", SEL, msel);

        // A long COMMIT hold with READY high gives exactly one beat.
        READY = 1'b1;
        sw = 8'($urandom);
        SW = sw;
        expect_txn(sw);
        b0 = beats;
        BTN_N[1] = 1'b0;
        step(100);
        BTN_N[1] = 1'b1;
        step(15);
        READY = 1'b0;
        check("one_beat", beats - b0, 1);

        // Randomized selections, operands and READY delays.
        for (int it = 0; it < 8; it++) begin
            int k = $urandom_range(0, 4);
            for (int j = 0; j < k; j++) next_press();
            check("rand_sel", SEL, msel);
            sw = 8'($urandom);
            SW = sw;
            expect_txn(sw);
            READY = ($urandom_range(0, 1) == 1);
            BTN_N[1] = 1'b0;
            wait_valid();
            SW = 8'($urandom);
            step($urandom_range(0, 4));
            READY = 1'b1;
            step(1);
            check("rand_valid_fall", VALID, 0);
            READY = 1'b0;
            BTN_N[1] = 1'b1;
            step(15);
        end

        // NEXT and COMMIT together: COMMIT wins and SEL stays put.
        while (msel != 0) next_press();
        sw = 8'($urandom);
        SW = sw;
        expect_txn(sw);
        READY = 1'b1;
        BTN_N = 2'b00;
        step(20);
        BTN_N = 2'b11;
        step(15);
        READY = 1'b0;
        check("simul_sel", SEL, 0);
        check("simul_op", OP, 0);

        // Reset in ISSUE: VALID drops at once and no beat is produced.
        next_press();
        BTN_N[1] = 1'b0;
        wait_valid();
        #2 RST_N = 1'b0;
        #1;
        check("rst_mid_valid", VALID, 0);
        check("rst_mid_sel", SEL, 0);
        BTN_N = 2'b11;
        step(3);
        RST_N = 1'b1;
        msel = 0;
        step(15);
        check("after_rst_valid", VALID, 0);
        check("after_rst_sel", SEL, 0);

`ifdef AUTO_REPEAT_EN
        // Hold NEXT for 65 cycles past the debounced press: one press step plus three repeats.
        sel0 = msel;
        BTN_N[0] = 1'b0;
        step(2 + DB + 65);
        BTN_N[0] = 1'b1;
        step(20);
        msel = (sel0 + 4) % 5;
        check("repeat_sel", SEL, msel);
`else
        sel0 = msel;
        BTN_N[0] = 1'b0;
        step(2 + DB + 65);
        BTN_N[0] = 1'b1;
        step(20);
        msel = (sel0 + 1) % 5;
        check("hold_one_step", SEL, msel);
`endif

        check("sb_empty", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
